// File: rtl/exec_sequencer_pkg.sv
// Shared definitions for the execute/control sequencer.
// Holds the datapath and register-index widths, the instruction field
// positions, the opcode and FSM state encodings, and an opcode decode helper.
package exec_sequencer_pkg;

    localparam int DATA_W    = 8;
    localparam int REG_W     = 1;
    localparam int MUL_STEPS = 8;

    // Instruction layout: [7:5] opcode, [4] dst, [3] srcA, [2] srcB, [1:0] unused.
    localparam int OPC_MSB  = 7;
    localparam int OPC_LSB  = 5;
    localparam int DST_BIT  = 4;
    localparam int SRCA_BIT = 3;
    localparam int SRCB_BIT = 2;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_MUL = 3'b101,
        OP_SHL = 3'b110,
        OP_NOP = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MUL   = 3'd3,
        ST_WRITE = 3'd4
    } state_e;

    function automatic opcode_e decode_opcode(input logic [DATA_W-1:0] ins);
        return opcode_e'(ins[OPC_MSB:OPC_LSB]);
    endfunction

endpackage

// File: rtl/exec_sequencer_mul.sv
// Iterative 8x8 shift-add multiplier.
// Ports:
//   clock, reset  - rising-edge clock, synchronous active-high reset (aborts)
//   start         - one-cycle pulse; loads a/b and clears the product
//   a, b          - multiplicand / multiplier, sampled on start
//   product       - 16-bit product, final after the edge on which done is high
//   done          - high during the last of the 8 iteration cycles
module shift_add_mul8
    import exec_sequencer_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic [2*DATA_W-1:0]   product,
    output logic                  done
);

    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [2:0]          count;
    logic                running;

    always_ff @(posedge clock) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            count   <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= {{DATA_W{1'b0}}, a};
            mplier  <= b;
            count   <= '0;
            running <= 1'b1;
        end else if (running) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 3'd1;
            if (count == 3'(MUL_STEPS - 1)) begin
                running <= 1'b0;
            end
        end
    end

    // Flags the final iteration so the sequencer can leave MUL on the same
    // edge that completes the product, keeping MUL exactly 8 cycles long.
    assign done    = running && (count == 3'(MUL_STEPS - 1));
    assign product = acc;

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle execute/control stage in front of a 2-entry 8-bit register file.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   instr_valid/instr_ready - instruction handshake; instr is 8 bits
//   rf_read_register1/2     - operand addresses (srcA/srcB of latched instr)
//   rf_read_data1/2         - combinational register file read data
//   rf_write_enable/_register/_data - one-cycle write port
//   busy, done              - not-idle status, one-cycle completion pulse
//   zero_flag, carry_flag   - flags of the last completed non-NOP op
//   state_debug             - current FSM state
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high. instr_ready is high only in IDLE outside reset;
// the producer must hold instr stable until the transfer, and instr_valid is
// ignored at all other times.
module exec_sequencer
    import exec_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [DATA_W-1:0] instr,
    output logic [REG_W-1:0]  rf_read_register1,
    output logic [REG_W-1:0]  rf_read_register2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write_enable,
    output logic [REG_W-1:0]  rf_write_register,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              busy,
    output logic              done,
    output logic              zero_flag,
    output logic              carry_flag,
    output state_e            state_debug
);

    state_e                state_q, state_d;
    opcode_e               op_q;
    logic [REG_W-1:0]      dst_q, srca_q, srcb_q;
    logic [DATA_W-1:0]     a_q, b_q;
    logic [DATA_W-1:0]     alu_res, alu_res_q;
    logic                  alu_carry, alu_carry_q;
    logic                  mul_start, mul_done;
    logic [2*DATA_W-1:0]   mul_product;
    logic [DATA_W-1:0]     wdata;
    logic                  wcarry;
    logic                  accept;
    logic                  unused_instr_bits;

    assign unused_instr_bits = ^instr[1:0];
    assign accept            = instr_valid && instr_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mul_start = 1'b0;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_READ;
            ST_READ:  state_d = ST_EXEC;
            ST_EXEC: begin
                if (op_q == OP_MUL) begin
                    mul_start = 1'b1;
                    state_d   = ST_MUL;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_MUL:   if (mul_done) state_d = ST_WRITE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // 9-bit add/subtract so bit 8 is the carry or the unsigned borrow.
    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
            OP_SUB: {alu_carry, alu_res} = {1'b0, a_q} - {1'b0, b_q};
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res   = {a_q[DATA_W-2:0], 1'b0};
                alu_carry = a_q[DATA_W-1];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_q        <= OP_NOP;
            dst_q       <= '0;
            srca_q      <= '0;
            srcb_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            alu_res_q   <= '0;
            alu_carry_q <= 1'b0;
            zero_flag   <= 1'b0;
            carry_flag  <= 1'b0;
        end else begin
            if (accept) begin
                op_q   <= decode_opcode(instr);
                dst_q  <= instr[DST_BIT];
                srca_q <= instr[SRCA_BIT];
                srcb_q <= instr[SRCB_BIT];
            end
            if (state_q == ST_READ) begin
                a_q <= rf_read_data1;
                b_q <= rf_read_data2;
            end
            if (state_q == ST_EXEC) begin
                alu_res_q   <= alu_res;
                alu_carry_q <= alu_carry;
            end
            if (state_q == ST_WRITE && op_q != OP_NOP) begin
                zero_flag  <= (wdata == '0);
                carry_flag <= wcarry;
            end
        end
    end

    shift_add_mul8 u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_q),
        .b       (b_q),
        .product (mul_product),
        .done    (mul_done)
    );

    // MUL results come straight from the multiplier's product register; all
    // other ops from the ALU result register loaded in EXEC.
    assign wdata  = (op_q == OP_MUL) ? mul_product[DATA_W-1:0] : alu_res_q;
    assign wcarry = (op_q == OP_MUL) ? (mul_product[2*DATA_W-1:DATA_W] != '0)
                                     : alu_carry_q;

    // Status and strobes are gated by reset so an aborted op never writes
    // (the register file lets write enable override its own reset).
    assign instr_ready       = (state_q == ST_IDLE) && !reset;
    assign busy              = (state_q != ST_IDLE) && !reset;
    assign done              = (state_q == ST_WRITE) && !reset;
    assign rf_write_enable   = done && (op_q != OP_NOP);
    assign rf_write_register = dst_q;
    assign rf_write_data     = wdata;
    assign rf_read_register1 = srca_q;
    assign rf_read_register2 = srcb_q;
    assign state_debug       = state_q;

endmodule
